bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL provide parameter NUM_MASTERS, default 3: number of requesting masters (CPU, DMA, PPU); legal range 1..8, other values an elaboration error.
REQ-002 SHALL provide parameter ADDR_W, default 16: address width.
REQ-003 SHALL provide parameter DATA_W, default 8: data width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 m_op  input  2*NUM_MASTERS  per-master bus_op_t request: 00 BUS_IDLE, 01 BUS_READ, 10 BUS_WRITE, 11 BUS_FINISHED_OP (hold bus).
REQ-007 m_addr  input  ADDR_W*NUM_MASTERS  per-master address.
REQ-008 m_wdata  input  DATA_W*NUM_MASTERS  per-master write data.
REQ-009 m_done  output  NUM_MASTERS  one-hot completion pulse.
REQ-010 m_rdata  output  DATA_W  read data shared by all masters; valid while m_done is high.
REQ-011 mem_read_en  output  1  read strobe to MMU.
REQ-012 mem_write_en  output  1  write strobe to MMU.
REQ-013 mem_addr  output  ADDR_W  address to MMU.
REQ-014 mem_wdata  output  DATA_W  write data to MMU.
REQ-015 mem_rdata  input  DATA_W  MMU read data, valid the cycle after mem_read_en.
REQ-016 busy  output  1  high in any state other than IDLE, or while a hold is active.

Function
REQ-017 FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-018 IDLE: SHALL select a winner from masters presenting BUS_READ/BUS_WRITE; latch index, op, addr, wdata; move to ACCESS; with no request, remain in IDLE.
REQ-019 ACCESS: SHALL drive mem_addr/mem_wdata from the latched values and assert exactly one of mem_read_en/mem_write_en for exactly one cycle; go to RESP.
REQ-020 RESP: SHALL register mem_rdata into m_rdata (reads only; writes leave m_rdata unchanged), pulse m_done[owner] for one cycle, and return to IDLE.
REQ-021 Latency: request sampled in IDLE cycle N -> mem strobe cycle N+1 -> m_done cycle N+2; back-to-back throughput is one transfer per 3 cycles.
REQ-022 Changes to the owner's m_op/m_addr/m_wdata after the IDLE sample SHALL be ignored until the transfer completes.
REQ-023 Hold: in IDLE, if the last owner presents BUS_FINISHED_OP, the arbiter SHALL set hold, grant no one, and keep busy high.
REQ-024 While hold is set, only the last owner SHALL be granted; its BUS_READ/BUS_WRITE is serviced immediately; its BUS_IDLE clears hold in that cycle, and arbitration among the others starts the next cycle.
REQ-025 BUS_FINISHED_OP from a non-owner SHALL be treated as BUS_IDLE.
REQ-026 mem_read_en, mem_write_en and m_done SHALL never be high outside ACCESS and RESP respectively; at most one bit of m_done SHALL be high.
REQ-027 With NUM_MASTERS=1 the block SHALL still function as a 3-cycle pass-through.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, hold=0, last owner=0, round-robin pointer=0, m_done=0, m_rdata=0, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-029 A transfer interrupted by reset SHALL be abandoned without completing or pulsing m_done; the first grant after release follows REQ-018.

Configuration
REQ-030 Macro BUS_ARB_ROUND_ROBIN_EN defined: winner SHALL be the first requester at or after the pointer, wrapping modulo NUM_MASTERS; the pointer becomes winner+1 (wrapping) on each grant.
REQ-031 Macro BUS_ARB_ROUND_ROBIN_EN undefined: fixed priority; the lowest-index requester SHALL win and no pointer exists.

Verification
REQ-032 Single read: master0 BUS_READ addr 0xC000, MMU returns 0x5A -> mem_read_en in cycle N+1 only, m_done=3'b001 and m_rdata=0x5A in cycle N+2.
REQ-033 Single write: master2 BUS_WRITE addr 0xFF40, wdata 0x91 -> mem_write_en, mem_addr=0xFF40, mem_wdata=0x91 for one cycle, then m_done=3'b100; m_rdata unchanged.
REQ-034 Contention, all 3 masters reading continuously: round-robin build -> grant order 0,1,2,0; fixed build -> master0 wins every time.
REQ-035 Hold: master1 completes, presents BUS_FINISHED_OP 5 cycles while master0 reads -> no grant and busy=1; master1 BUS_WRITE is served next; master1 BUS_IDLE -> master0 granted the following cycle.
REQ-036 Reset in ACCESS state -> all outputs 0 immediately, no m_done pulse; after release a pending read completes in 3 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - three-state arbiter granting one master at a time to a shared MMU port
// Optional macro BUS_ARB_ROUND_ROBIN_EN selects round-robin arbitration; fixed priority otherwise.
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*NUM_MASTERS-1:0]      m_op,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          mem_read_en,
  output logic                          mem_write_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  generate
    if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_num_masters
      $error("bus_arbiter: NUM_MASTERS must be in 1..8");
    end
  endgenerate

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_FIN   = 2'b11;

  logic [1:0]        state_q, state_d;
  logic              hold_q, hold_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  logic [IDX_W-1:0]       win_idx;
  logic [1:0]             owner_op, win_op;
  logic [ADDR_W-1:0]      win_addr;
  logic [DATA_W-1:0]      win_wdata;
  logic                   grant;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i] = (m_op[2*i +: 2] == OP_READ) || (m_op[2*i +: 2] == OP_WRITE);
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan starts at the pointer so the most recent winner is considered last.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!arb_found && req[(int'(ptr_q) + k) % NUM_MASTERS]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((int'(ptr_q) + k) % NUM_MASTERS);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    arb_found = |req;
    arb_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) arb_idx = IDX_W'(i);
    end
  end
`endif

  // While holding, only the previous owner is eligible.
  assign win_idx = hold_q ? owner_q : arb_idx;

  always_comb begin
    owner_op  = OP_IDLE;
    win_op    = OP_IDLE;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == IDX_W'(i)) owner_op = m_op[2*i +: 2];
      if (win_idx == IDX_W'(i)) begin
        win_op    = m_op[2*i +: 2];
        win_addr  = m_addr[ADDR_W*i +: ADDR_W];
        win_wdata = m_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_q) begin
          if (owner_op == OP_READ || owner_op == OP_WRITE) grant = 1'b1;
          else if (owner_op == OP_IDLE) hold_d = 1'b0;
        end else if (owner_op == OP_FIN) begin
          hold_d = 1'b1;
        end else begin
          grant = arb_found;
        end
        if (grant) begin
          state_d = S_ACCESS;
          owner_d = win_idx;
          write_d = (win_op == OP_WRITE);
          addr_d  = win_addr;
          wdata_d = win_wdata;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (!write_q) rdata_d = mem_rdata;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hold_q  <= 1'b0;
      owner_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_done[i] = (state_q == S_RESP) && (owner_q == IDX_W'(i));
    end
  end

  // Read data is forwarded during RESP so it is valid alongside m_done.
  assign m_rdata      = (state_q == S_RESP && !write_q) ? mem_rdata : rdata_q;
  assign mem_read_en  = (state_q == S_ACCESS) && !write_q;
  assign mem_write_en = (state_q == S_ACCESS) && write_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = (state_q != S_IDLE) || hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - transaction-level scoreboard bench for bus_arbiter
module tb_bus_arbiter;
  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  localparam logic [1:0] IDL = 2'b00, RD = 2'b01, WR = 2'b10, FIN = 2'b11;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [2*NM-1:0]    m_op = '0;
  logic [AW*NM-1:0]   m_addr = '0;
  logic [DW*NM-1:0]   m_wdata = '0;
  logic [NM-1:0]      m_done;
  logic [DW-1:0]      m_rdata;
  logic               mem_read_en, mem_write_en;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata = '0;
  logic               busy;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .m_op(m_op), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a == 16'hC000) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // MMU stub: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_read_en) mem_rdata <= memf(mem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one transfer in flight, tracked by its age since the grant.
  bit          act = 0;
  int          age = 0;
  bit          hold = 0;
  int          last = 0;
  int          ptr = 0;
  int          cm = 0;
  bit          cwr = 0;
  logic [15:0] caddr = '0;
  logic [7:0]  cwd = '0;
  logic [7:0]  lrd = '0;
  int          win;

  function automatic logic [1:0] opof(input int i);
    return m_op[2*i +: 2];
  endfunction

  function automatic bit isreq(input int i);
    return opof(i) == RD || opof(i) == WR;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      act = 0; age = 0; hold = 0; last = 0; ptr = 0; lrd = '0;
    end else if (act) begin
      if (age == 1) age = 2;
      else begin
        act = 0;
        if (!cwr) lrd = memf(caddr);
      end
    end else begin
      win = -1;
      if (hold) begin
        if (isreq(last)) win = last;
        else if (opof(last) == IDL) hold = 0;
      end else if (opof(last) == FIN) begin
        hold = 1;
      end else begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NM; k++) if (win < 0 && isreq((ptr + k) % NM)) win = (ptr + k) % NM;
`else
        for (int i = 0; i < NM; i++) if (win < 0 && isreq(i)) win = i;
`endif
      end
      if (win >= 0) begin
        act = 1; age = 1; cm = win; cwr = (opof(win) == WR);
        caddr = m_addr[AW*win +: AW]; cwd = m_wdata[DW*win +: DW];
        last = win; ptr = (win + 1) % NM;
      end
    end
  end

  task automatic step();
    logic [NM-1:0] e_done;
    @(posedge clk);
    @(negedge clk);
    e_done = (act && age == 2) ? NM'(1 << cm) : '0;
    check_eq("m_done", 32'(m_done), 32'(e_done));
    check_eq("mem_read_en", 32'(mem_read_en), 32'(act && age == 1 && !cwr));
    check_eq("mem_write_en", 32'(mem_write_en), 32'(act && age == 1 && cwr));
    if (act && age == 1) check_eq("mem_addr", 32'(mem_addr), 32'(caddr));
    if (act && age == 1 && cwr) check_eq("mem_wdata", 32'(mem_wdata), 32'(cwd));
    check_eq("m_rdata", 32'(m_rdata), 32'((act && age == 2 && !cwr) ? memf(caddr) : lrd));
    check_eq("busy", 32'(busy), 32'(act || hold));
  endtask

  task automatic set_m(input int i, input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    m_op[2*i +: 2]   = op;
    m_addr[AW*i +: AW] = a;
    m_wdata[DW*i +: DW] = d;
  endtask

  task automatic all_idle();
    for (int i = 0; i < NM; i++) set_m(i, IDL, '0, '0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    steps(3);
    reset = 1'b1;

    // Single read by master 0
    set_m(0, RD, 16'hC000, 8'h00);
    step();
    set_m(0, WR, 16'h1234, 8'hEE);
    step();
    set_m(0, IDL, '0, '0);
    steps(3);

    // Single write by master 2; m_rdata must keep 0x5A
    set_m(2, WR, 16'hFF40, 8'h91);
    step();
    set_m(2, IDL, '0, '0);
    steps(3);
    check_eq("rdata_kept", 32'(m_rdata), 32'h5A);

    // Contention: everyone reads continuously
    for (int i = 0; i < NM; i++) set_m(i, RD, 16'h2000 + 16'(i), 8'h00);
    steps(13);
    all_idle();
    steps(3);

    // Hold sequence by master 1
    set_m(1, RD, 16'h4444, 8'h00);
    step();
    set_m(1, FIN, '0, '0);
    set_m(0, RD, 16'h0100, 8'h00);
    steps(2);
    steps(5);
    set_m(1, WR, 16'h5555, 8'h77);
    step();
    set_m(1, FIN, '0, '0);
    steps(3);
    set_m(1, IDL, '0, '0);
    steps(5);
    all_idle();
    steps(3);

    // Reset while in ACCESS
    set_m(0, RD, 16'h0ABC, 8'h00);
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_m_done", 32'(m_done), 32'h0);
    check_eq("rst_m_rdata", 32'(m_rdata), 32'h0);
    check_eq("rst_rd_en", 32'(mem_read_en), 32'h0);
    check_eq("rst_wr_en", 32'(mem_write_en), 32'h0);
    check_eq("rst_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    steps(2);
    reset = 1'b1;
    steps(4);
    all_idle();
    steps(2);

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NM; i++) begin
        int r;
        logic [1:0] op;
        r = $urandom_range(0, 99);
        op = (r < 40) ? IDL : (r < 65) ? RD : (r < 90) ? WR : FIN;
        set_m(i, op, 16'($urandom), 8'($urandom));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
